// File: rtl/pico_txn_sequencer.sv
// pico_txn_sequencer: turns SPI bytes (address byte, then data bytes)
// into register-bank writes with an auto-incrementing address pointer.
//
// Ports:
//   iclk, rst            clock, async active-high reset
//   byte_valid/byte_data received byte strobe and value
//   frame_end            frame finished strobe
//   clear_err            clears err_addr/err_ovf
//   wr_valid/wr_ready    write handshake, wr_addr/wr_data payload
//   mux_sel              readback select (address pointer)
//   busy                 frame in progress or write pending
//   err_addr, err_ovf    sticky error flags
module pico_txn_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 8,
    parameter bit WRAP     = 1'b1
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              frame_end,
    input  logic              clear_err,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] mux_sel,
    output logic              busy,
    output logic              err_addr,
    output logic              err_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DROP
    } state_t;

    localparam logic [8:0]        NREGS = 9'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [7:0]        wr_data_n;
    logic              wr_valid_n;
    logic              ovr, ovr_n;
    logic              err_addr_set;
    logic              err_ovf_set;
    logic              addr_ok;
    logic              can_issue;

    // Full 8-bit compare: any bit above the register range is a bad address.
    assign addr_ok   = {1'b0, byte_data} < NREGS;
    assign can_issue = !wr_valid || wr_ready;
    assign mux_sel   = ptr;
    assign busy      = (state != IDLE) || wr_valid;

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        ovr_n        = ovr;
        wr_valid_n   = wr_valid && !wr_ready;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        err_addr_set = 1'b0;
        err_ovf_set  = 1'b0;
        if (byte_valid) begin
            unique case (state)
                IDLE: begin
                    if (addr_ok) begin
                        ptr_n   = byte_data[ADDR_W-1:0];
                        state_n = DATA;
                    end else begin
                        err_addr_set = 1'b1;
                        state_n      = DROP;
                    end
                end
                DATA: begin
                    if (can_issue) begin
                        wr_valid_n = 1'b1;
                        wr_addr_n  = ptr;
                        wr_data_n  = byte_data;
                        if (ptr != LAST) begin
                            ptr_n = ptr + ADDR_W'(1);
                        end else if (WRAP) begin
                            ptr_n = '0;
                        end else begin
                            // Overrun: last write still goes out, later bytes flag err_addr.
                            state_n = DROP;
                            ovr_n   = 1'b1;
                        end
                    end else begin
                        err_ovf_set = 1'b1;
                    end
                end
                DROP: begin
                    err_addr_set = ovr;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        // Frame end overrides the state after the byte (if any) is handled.
        if (frame_end) begin
            state_n = IDLE;
            ovr_n   = 1'b0;
        end
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            ovr      <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err_addr <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            ovr      <= ovr_n;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            err_addr <= err_addr_set || (err_addr && !clear_err);
            err_ovf  <= err_ovf_set || (err_ovf && !clear_err);
        end
    end

endmodule

// File: tb/tb_pico_txn_sequencer.sv
// Bench for pico_txn_sequencer: WRAP=1 (index 1) and WRAP=0 (index 0)
// instances share stimulus and are checked against a frame-level model.
module tb_pico_txn_sequencer;

    localparam int NREGS = 16;

    logic       iclk;
    logic       rst;
    logic       bv;
    logic [7:0] bd;
    logic       fe;
    logic       clr;
    logic       rdy;

    logic       wv [2];
    logic [7:0] wa [2];
    logic [7:0] wd [2];
    logic [7:0] mx [2];
    logic       bz [2];
    logic       ea [2];
    logic       eo [2];

    int errors = 0;
    int checks = 0;
    bit go = 0;

    // Model: frame-level view of each instance.
    bit m_want [2];
    bit m_drop [2];
    bit m_ovr  [2];
    bit m_pv   [2];
    bit m_ea   [2];
    bit m_eo   [2];
    int m_ptr  [2];
    int m_pa   [2];
    int m_pd   [2];

    pico_txn_sequencer #(.NUM_REGS(NREGS), .ADDR_W(8), .WRAP(1'b0)) u_nowrap (
        .iclk(iclk), .rst(rst), .byte_valid(bv), .byte_data(bd),
        .frame_end(fe), .clear_err(clr), .wr_valid(wv[0]), .wr_ready(rdy),
        .wr_addr(wa[0]), .wr_data(wd[0]), .mux_sel(mx[0]), .busy(bz[0]),
        .err_addr(ea[0]), .err_ovf(eo[0])
    );

    pico_txn_sequencer #(.NUM_REGS(NREGS), .ADDR_W(8), .WRAP(1'b1)) u_wrap (
        .iclk(iclk), .rst(rst), .byte_valid(bv), .byte_data(bd),
        .frame_end(fe), .clear_err(clr), .wr_valid(wv[1]), .wr_ready(rdy),
        .wr_addr(wa[1]), .wr_data(wd[1]), .mux_sel(mx[1]), .busy(bz[1]),
        .err_addr(ea[1]), .err_ovf(eo[1])
    );

    initial begin
        iclk = 0;
        forever #5 iclk = ~iclk;
    end

    function automatic void chk(string nm, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_want[k] = 1; m_drop[k] = 0; m_ovr[k] = 0;
            m_pv[k] = 0; m_ea[k] = 0; m_eo[k] = 0;
            m_ptr[k] = 0; m_pa[k] = 0; m_pd[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        bit acc;
        bit nw;
        bit sa;
        bit so;
        int na;
        int nd;
        acc = !m_pv[k] || rdy;
        nw = 0; sa = 0; so = 0; na = 0; nd = 0;
        if (bv) begin
            if (m_want[k]) begin
                m_want[k] = 0;
                if (int'(bd) < NREGS) m_ptr[k] = int'(bd);
                else begin
                    sa = 1;
                    m_drop[k] = 1;
                end
            end else if (m_drop[k]) begin
                sa = m_ovr[k];
            end else if (acc) begin
                nw = 1;
                na = m_ptr[k];
                nd = int'(bd);
                if (m_ptr[k] < NREGS - 1) m_ptr[k] = m_ptr[k] + 1;
                else if (k == 1) m_ptr[k] = 0;
                else begin
                    m_drop[k] = 1;
                    m_ovr[k] = 1;
                end
            end else begin
                so = 1;
            end
        end
        m_ea[k] = sa || (m_ea[k] && !clr);
        m_eo[k] = so || (m_eo[k] && !clr);
        if (nw) begin
            m_pv[k] = 1; m_pa[k] = na; m_pd[k] = nd;
        end else if (m_pv[k] && rdy) begin
            m_pv[k] = 0;
        end
        if (fe) begin
            m_want[k] = 1; m_drop[k] = 0; m_ovr[k] = 0;
        end
    endtask

    always @(posedge iclk) begin
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge iclk) begin
        if (go && !rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("wr_valid", k, int'(wv[k]), int'(m_pv[k]));
                chk("mux_sel", k, int'(mx[k]), m_ptr[k]);
                chk("busy", k, int'(bz[k]), int'(!m_want[k] || m_pv[k]));
                chk("err_addr", k, int'(ea[k]), int'(m_ea[k]));
                chk("err_ovf", k, int'(eo[k]), int'(m_eo[k]));
                if (m_pv[k]) begin
                    chk("wr_addr", k, int'(wa[k]), m_pa[k]);
                    chk("wr_data", k, int'(wd[k]), m_pd[k]);
                end
            end
        end
    end

    task automatic drive(bit v, int d, bit f, bit r, bit c);
        @(negedge iclk);
        #1;
        bv = v; bd = 8'(d); fe = f; rdy = r; clr = c;
    endtask

    task automatic check_zero(string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_wv"}, k, int'(wv[k]), 0);
            chk({nm, "_wa"}, k, int'(wa[k]), 0);
            chk({nm, "_wd"}, k, int'(wd[k]), 0);
            chk({nm, "_mux"}, k, int'(mx[k]), 0);
            chk({nm, "_busy"}, k, int'(bz[k]), 0);
            chk({nm, "_ea"}, k, int'(ea[k]), 0);
            chk({nm, "_eo"}, k, int'(eo[k]), 0);
        end
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next edge.
    task automatic async_rst();
        @(negedge iclk);
        #1;
        bv = 0; bd = 0; fe = 0; rdy = 0; clr = 0;
        #1;
        rst = 1;
        model_reset();
        #1;
        check_zero("arst");
        @(negedge iclk);
        #1;
        rst = 0;
    endtask

    task automatic lit_wr(string nm, int k, int a, int d);
        chk({nm, "_wv"}, k, int'(wv[k]), 1);
        chk({nm, "_wa"}, k, int'(wa[k]), a);
        chk({nm, "_wd"}, k, int'(wd[k]), d);
    endtask

    initial begin
        rst = 1; bv = 0; bd = 0; fe = 0; rdy = 0; clr = 0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge iclk);
        #1;
        rst = 0;
        go = 1;

        // Simple frame: address 3, two data bytes.
        drive(1, 8'h03, 0, 1, 0);
        drive(1, 8'hAA, 0, 1, 0);
        drive(1, 8'hBB, 0, 1, 0);
        for (int k = 0; k < 2; k++) lit_wr("t1a", k, 3, 8'hAA);
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) lit_wr("t1b", k, 4, 8'hBB);
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t1_idle_wv", k, int'(wv[k]), 0);
            chk("t1_mux", k, int'(mx[k]), 5);
        end
        drive(0, 0, 1, 1, 0);

        // Last register: wrap vs overrun.
        drive(1, 8'h0F, 0, 1, 0);
        drive(1, 8'h11, 0, 1, 0);
        drive(1, 8'h22, 0, 1, 0);
        for (int k = 0; k < 2; k++) lit_wr("t2a", k, 15, 8'h11);
        drive(0, 0, 0, 1, 0);
        lit_wr("t2b", 1, 0, 8'h22);
        chk("t2_mux", 1, int'(mx[1]), 1);
        chk("t2_ea", 1, int'(ea[1]), 0);
        chk("t3_wv", 0, int'(wv[0]), 0);
        chk("t3_ea", 0, int'(ea[0]), 1);
        chk("t3_mux", 0, int'(mx[0]), 15);
        chk("t3_busy", 0, int'(bz[0]), 1);
        drive(0, 0, 1, 1, 0);

        // Bad address byte drops the frame.
        drive(0, 0, 0, 1, 1);
        drive(1, 8'h40, 0, 1, 0);
        drive(1, 8'h55, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t4_ea", k, int'(ea[k]), 1);
            chk("t4_wv", k, int'(wv[k]), 0);
        end
        chk("t4_mux", 1, int'(mx[1]), 1);
        chk("t4_mux", 0, int'(mx[0]), 15);
        drive(0, 0, 0, 1, 1);
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'h77, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            lit_wr("t4n", k, 1, 8'h77);
            chk("t4n_ea", k, int'(ea[k]), 0);
        end
        drive(0, 0, 1, 1, 0);

        // Stalled bank: second byte overflows.
        drive(1, 8'h02, 0, 0, 0);
        drive(1, 8'h10, 0, 0, 0);
        drive(1, 8'h20, 0, 0, 0);
        for (int k = 0; k < 2; k++) lit_wr("t5a", k, 2, 8'h10);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            lit_wr("t5b", k, 2, 8'h10);
            chk("t5_eo", k, int'(eo[k]), 1);
        end
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t5_done", k, int'(wv[k]), 0);
            chk("t5_mux", k, int'(mx[k]), 3);
        end
        drive(0, 0, 1, 1, 0);

        // Data byte with frame_end, then reset during a stalled write.
        drive(1, 8'h06, 0, 0, 0);
        drive(1, 8'h33, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            lit_wr("t6", k, 6, 8'h33);
            chk("t6_busy", k, int'(bz[k]), 1);
            chk("t6_mux", k, int'(mx[k]), 7);
        end
        drive(0, 0, 0, 0, 0);
        async_rst();

        // Random traffic.
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                async_rst();
            end else begin
                drive($urandom_range(0, 99) < 40,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 17)),
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 70,
                      $urandom_range(0, 99) < 3);
            end
        end
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
